// File: rtl/marc_main_memory.sv
// marc_main_memory: word-addressed main memory behind the mARC memory port.
// Provides a req/ready handshake, programmable wait states, alignment and
// window checking, and a one-cycle error pulse for rejected accesses.
module marc_main_memory #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_LOG2  = 12,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam int         WORD_W    = ADDR_W - 1;
  localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_waitCnt;
  logic [3:0]            w_nextWaitCnt;
  logic                  w_fire;

  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_rw;

  logic [ADDR_W-1:0]     w_opAddr;
  logic [DATA_W-1:0]     w_opWdata;
  logic                  w_opRw;

  logic [ADDR_W-1:0]     w_offset;
  logic [WORD_W-1:0]     w_wordOff;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_valid;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_ready;
  logic                  r_err;

  // With no wait states the access completes straight out of IDLE, so the
  // live bus values are used; otherwise the values latched at acceptance.
  assign w_opAddr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_opWdata = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_opRw    = (r_state == S_IDLE) ? rw    : r_rw;

  // Below-window addresses are caught by the compare, never by the wrapped offset.
  assign w_offset  = w_opAddr - BASE;
  assign w_wordOff = WORD_W'(w_offset >> 1);
  assign w_idx     = w_wordOff[DEPTH_LOG2-1:0];
  assign w_valid   = !w_opAddr[0] && (w_opAddr >= BASE) &&
                     ((w_wordOff >> DEPTH_LOG2) == '0);

  // Next-state, wait counter and the completion strobe that fires on the edge into ACK.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_fire        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_nextWaitCnt = '0;
        if (req) begin
          if (WAIT_STATES > 0) begin
            w_nextState = S_WAIT;
          end else begin
            w_nextState = S_ACK;
            w_fire      = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_waitCnt == LAST_WAIT) begin
          w_nextState   = S_ACK;
          w_nextWaitCnt = '0;
          w_fire        = 1'b1;
        end else begin
          w_nextWaitCnt = r_waitCnt + 4'd1;
        end
      end
      S_ACK: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State, request latch and the registered ready/err/rdata seen during ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_waitCnt <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      r_ready   <= w_fire;
      r_err     <= w_fire & ~w_valid;
      if (r_state == S_IDLE && req) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_rw    <= rw;
      end
      if (w_fire) begin
        if (!w_valid) begin
          r_rdata <= '0;
        end else if (!w_opRw) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Array write, suppressed while reset is held so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (reset && w_fire && w_valid && w_opRw) begin
      r_mem[w_idx] <= w_opWdata;
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_marc_main_memory.sv
// tb_marc_main_memory: self-checking bench for marc_main_memory. Three
// instances (1, 0 and 3 wait states; the last with a 0x1000 base window)
// share the address/data/rw bus and reset, each with its own req line.
module tb_marc_main_memory;

  localparam int NDUT = 3;

  typedef struct {
    int          sel;
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
  } access_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        req   [NDUT];
  logic [15:0] rdata [NDUT];
  logic        ready [NDUT];
  logic        err   [NDUT];
  logic        busy  [NDUT];

  int errors = 0;
  int checks = 0;

  logic [15:0] modelMem [int];
  logic [15:0] modelRdata [NDUT];
  bit          modelKnown [NDUT];

  always #5 clk = ~clk;

  marc_main_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .BASE(16'h0000), .WAIT_STATES(1)) u_dutA (
    .clk(clk), .reset(reset), .req(req[0]), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));

  marc_main_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .BASE(16'h0000), .WAIT_STATES(0)) u_dutB (
    .clk(clk), .reset(reset), .req(req[1]), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));

  marc_main_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .BASE(16'h1000), .WAIT_STATES(3)) u_dutC (
    .clk(clk), .reset(reset), .req(req[2]), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2]));

  function automatic int waitOf(int sel);
    case (sel)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] baseOf(int sel);
    return (sel == 2) ? 16'h1000 : 16'h0000;
  endfunction

  function automatic bit isValid(int sel, logic [15:0] a);
    logic [15:0] off;
    off = a - baseOf(sel);
    return (a[0] == 1'b0) && (a >= baseOf(sel)) && ((off >> 1) < 16'd4096);
  endfunction

  function automatic int keyOf(int sel, logic [15:0] a);
    logic [15:0] off;
    off = a - baseOf(sel);
    return sel * 65536 + int'(off >> 1);
  endfunction

  // Reference model: memory contents per instance plus the last returned word.
  task automatic predict(input int sel, input bit wr, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] expD, output bit expE, output bit known);
    int k;
    expE = !isValid(sel, a);
    k    = keyOf(sel, a);
    if (expE) begin
      modelRdata[sel] = 16'h0000;
      modelKnown[sel] = 1'b1;
    end else if (wr) begin
      modelMem[k] = d;
    end else if (modelMem.exists(k)) begin
      modelRdata[sel] = modelMem[k];
      modelKnown[sel] = 1'b1;
    end else begin
      modelKnown[sel] = 1'b0;
    end
    expD  = modelRdata[sel];
    known = modelKnown[sel];
  endtask

  task automatic modelReset();
    for (int s = 0; s < NDUT; s++) begin
      modelRdata[s] = 16'h0000;
      modelKnown[s] = 1'b1;
    end
  endtask

  // Drives one access, scrambles the bus once accepted, and captures what the DUT returned.
  task automatic doAccess(input int sel, input bit wr, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] obsD, output logic obsE,
                          output logic busy1, output logic readyAfter, output logic busyAfter);
    @(posedge clk); #1;
    rw       = wr;
    addr     = a;
    wdata    = d;
    req[sel] = 1'b1;
    @(posedge clk); #1;
    req[sel] = 1'b0;
    rw       = ~wr;
    addr     = 16'($urandom);
    wdata    = 16'($urandom);
    lat   = 0;
    obsD  = '0;
    obsE  = 1'b0;
    busy1 = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy[sel];
      if (ready[sel] === 1'b1) begin
        lat  = c;
        obsD = rdata[sel];
        obsE = err[sel];
      end
    end
    @(negedge clk);
    readyAfter = ready[sel];
    busyAfter  = busy[sel];
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int s = 0; s < NDUT; s++) req[s] = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (rdata[s] !== 16'h0000 || ready[s] !== 1'b0 || err[s] !== 1'b0 || busy[s] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: rdata=%h ready=%b err=%b busy=%b, want all zero",
                 s, rdata[s], ready[s], err[s], busy[s]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    int lat; logic [15:0] obsD; logic obsE, b1, rA, bA;
    logic [15:0] expD; bit expE, known;
    predict(0, 1'b1, 16'h0040, 16'h5140, expD, expE, known);
    doAccess(0, 1'b1, 16'h0040, 16'h5140, lat, obsD, obsE, b1, rA, bA);
    predict(0, 1'b0, 16'h0040, 16'h0000, expD, expE, known);
    doAccess(0, 1'b0, 16'h0040, 16'h0000, lat, obsD, obsE, b1, rA, bA);
    checks++;
    if (lat != 2) begin
      errors++; $display("[TB] FAIL single_read latency: got %0d want 2", lat);
    end
    checks++;
    if (obsD !== 16'h5140 || obsE !== 1'b0) begin
      errors++; $display("[TB] FAIL single_read data: got %h err=%b want 5140 err=0", obsD, obsE);
    end
  endtask

  task automatic test_write_read();
    access_t tbl [4];
    int lat; logic [15:0] obsD; logic obsE, b1, rA, bA;
    logic [15:0] expD; bit expE, known;
    tbl = '{'{0, 1'b1, 16'd2050, 16'h7777},
            '{0, 1'b1, 16'd2048, 16'h0800},
            '{0, 1'b0, 16'd2048, 16'h0000},
            '{0, 1'b0, 16'd2050, 16'h0000}};
    foreach (tbl[i]) begin
      predict(tbl[i].sel, tbl[i].wr, tbl[i].a, tbl[i].d, expD, expE, known);
      doAccess(tbl[i].sel, tbl[i].wr, tbl[i].a, tbl[i].d, lat, obsD, obsE, b1, rA, bA);
      checks++;
      if (lat != waitOf(tbl[i].sel) + 1) begin
        errors++; $display("[TB] FAIL wr_rd[%0d] latency: got %0d want %0d", i, lat, waitOf(tbl[i].sel) + 1);
      end
      checks++;
      if (obsD !== expD || obsE !== expE) begin
        errors++; $display("[TB] FAIL wr_rd[%0d] data: got %h err=%b want %h err=%b", i, obsD, obsE, expD, expE);
      end
    end
  endtask

  task automatic test_errors();
    access_t tbl [10];
    int lat; logic [15:0] obsD; logic obsE, b1, rA, bA;
    logic [15:0] expD; bit expE, known;
    tbl = '{'{0, 1'b1, 16'h0041, 16'hDEAD},
            '{0, 1'b0, 16'h0040, 16'h0000},
            '{2, 1'b0, 16'h0FFE, 16'h0000},
            '{0, 1'b0, 16'h2000, 16'h0000},
            '{0, 1'b1, 16'h1FFE, 16'hA5A5},
            '{0, 1'b0, 16'h1FFE, 16'h0000},
            '{2, 1'b1, 16'h1000, 16'h3C3C},
            '{2, 1'b0, 16'h1000, 16'h0000},
            '{2, 1'b0, 16'h3000, 16'h0000},
            '{1, 1'b0, 16'hFFFF, 16'h0000}};
    foreach (tbl[i]) begin
      predict(tbl[i].sel, tbl[i].wr, tbl[i].a, tbl[i].d, expD, expE, known);
      doAccess(tbl[i].sel, tbl[i].wr, tbl[i].a, tbl[i].d, lat, obsD, obsE, b1, rA, bA);
      checks++;
      if (lat != waitOf(tbl[i].sel) + 1) begin
        errors++; $display("[TB] FAIL errors[%0d] latency: got %0d want %0d", i, lat, waitOf(tbl[i].sel) + 1);
      end
      checks++;
      if (obsE !== expE) begin
        errors++; $display("[TB] FAIL errors[%0d] err: got %b want %b", i, obsE, expE);
      end
      if (known) begin
        checks++;
        if (obsD !== expD) begin
          errors++; $display("[TB] FAIL errors[%0d] rdata: got %h want %h", i, obsD, expD);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, v;
    int lat, pulses, lastCyc; logic [15:0] obsD; logic obsE, b1, rA, bA;
    logic [15:0] expD; bit expE, known;
    for (int s = 0; s < NDUT; s++) begin
      a = (s == 2) ? 16'h1010 : 16'h0060;
      v = 16'h1B00 + 16'(s);
      predict(s, 1'b1, a, v, expD, expE, known);
      doAccess(s, 1'b1, a, v, lat, obsD, obsE, b1, rA, bA);
      @(posedge clk); #1;
      rw     = 1'b0;
      addr   = a;
      req[s] = 1'b1;
      pulses  = 0;
      lastCyc = -1;
      for (int c = 0; c < 60 && pulses < 4; c++) begin
        @(negedge clk);
        if (ready[s] === 1'b1) begin
          if (pulses > 0) begin
            checks++;
            if (c - lastCyc != waitOf(s) + 2) begin
              errors++; $display("[TB] FAIL b2b dut%0d spacing: got %0d want %0d", s, c - lastCyc, waitOf(s) + 2);
            end
          end
          checks++;
          if (rdata[s] !== v || err[s] !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b dut%0d data: got %h err=%b want %h err=0", s, rdata[s], err[s], v);
          end
          lastCyc = c;
          pulses++;
        end
      end
      req[s] = 1'b0;
      modelRdata[s] = v;
      modelKnown[s] = 1'b1;
      checks++;
      if (pulses != 4) begin
        errors++; $display("[TB] FAIL b2b dut%0d pulses: got %0d want 4", s, pulses);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int sel, k, mode;
    bit wr;
    logic [15:0] a, d;
    int lat; logic [15:0] obsD; logic obsE, b1, rA, bA;
    logic [15:0] expD; bit expE, known;
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 2);
      wr   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      d    = 16'($urandom);
      case (mode)
        0:       begin k = $urandom_range(0, 15);      a = baseOf(sel) + 16'(2 * k);     end
        1:       begin k = $urandom_range(4090, 4100); a = baseOf(sel) + 16'(2 * k);     end
        2:       begin a = 16'($urandom);                                                end
        default: begin k = $urandom_range(0, 15);      a = baseOf(sel) + 16'(2 * k + 1); end
      endcase
      predict(sel, wr, a, d, expD, expE, known);
      doAccess(sel, wr, a, d, lat, obsD, obsE, b1, rA, bA);
      checks++;
      if (lat != waitOf(sel) + 1 || b1 !== 1'b1) begin
        errors++; $display("[TB] FAIL rand[%0d] dut%0d timing: lat=%0d busy=%b want lat=%0d busy=1", i, sel, lat, b1, waitOf(sel) + 1);
      end
      checks++;
      if (obsE !== expE) begin
        errors++; $display("[TB] FAIL rand[%0d] dut%0d addr=%h err: got %b want %b", i, sel, a, obsE, expE);
      end
      if (known) begin
        checks++;
        if (obsD !== expD) begin
          errors++; $display("[TB] FAIL rand[%0d] dut%0d addr=%h rdata: got %h want %h", i, sel, a, obsD, expD);
        end
      end
      checks++;
      if (rA !== 1'b0 || bA !== 1'b0) begin
        errors++; $display("[TB] FAIL rand[%0d] dut%0d after ack: ready=%b busy=%b want 0 0", i, sel, rA, bA);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] obsD; logic obsE, b1, rA, bA;
    logic [15:0] expD; bit expE, known;
    predict(0, 1'b1, 16'h0100, 16'h1234, expD, expE, known);
    doAccess(0, 1'b1, 16'h0100, 16'h1234, lat, obsD, obsE, b1, rA, bA);
    @(posedge clk); #1;
    rw     = 1'b1;
    addr   = 16'h0100;
    wdata  = 16'hBEEF;
    req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || ready[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid in wait: busy=%b ready=%b want 1 0", busy[0], ready[0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b0 || rdata[0] !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_mid abort: busy=%b ready=%b rdata=%h want 0 0 0000", busy[0], ready[0], rdata[0]);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid held: busy=%b ready=%b want 0 0", busy[0], ready[0]);
    end
    reset = 1'b1;
    modelReset();
    predict(0, 1'b0, 16'h0100, 16'h0000, expD, expE, known);
    doAccess(0, 1'b0, 16'h0100, 16'h0000, lat, obsD, obsE, b1, rA, bA);
    checks++;
    if (obsD !== 16'h1234 || obsE !== 1'b0 || lat != 2) begin
      errors++; $display("[TB] FAIL reset_mid old value: got %h err=%b lat=%0d want 1234 err=0 lat=2", obsD, obsE, lat);
    end
  endtask

  // Sequences the scenarios and prints the summary.
  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bounds the whole run in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
